// File: rtl/clkdiv_bcd_unit_pkg.sv
// Shared constants and types for the MM:SS display timebase/BCD unit.
// Default divider halves assume a 100 MHz board clock.
package clkdiv_bcd_pkg;
   localparam int CLK_HZ             = 100_000_000;
   localparam int SEC_HALF_DEFAULT   = CLK_HZ / 2;
   localparam int DIGIT_HALF_DEFAULT = CLK_HZ / 2000;

   typedef logic [3:0] bcd_digit_t;

   typedef struct packed {
      bcd_digit_t hundreds;
      bcd_digit_t tens;
      bcd_digit_t ones;
   } bcd_t;

   // Divider counter width: ceil(log2(half)), never less than one bit.
   function automatic int cnt_width(input int half);
      return (half > 1) ? $clog2(half) : 1;
   endfunction
endpackage

// File: rtl/clkdiv_bcd_unit_if.sv
// Value-in / strobes-and-digits-out bundle between the display top and this unit.
// The slave side is the unit; the master side is whoever supplies the value.
interface clkdiv_bcd_unit_if;
   import clkdiv_bcd_pkg::*;

   logic [7:0] eight_bit_value;
   logic       divided_clk;
   logic       digit_clk;
   bcd_digit_t ones;
   bcd_digit_t tens;
   bcd_digit_t hundreds;

   modport master (
      output eight_bit_value,
      input  divided_clk, digit_clk, ones, tens, hundreds
   );

   modport slave (
      input  eight_bit_value,
      output divided_clk, digit_clk, ones, tens, hundreds
   );
endinterface

// File: rtl/clkdiv_bcd_unit_bin8_to_bcd.sv
// Combinational double-dabble (shift-add-3) of an 8-bit binary value into
// three BCD digits.
module bin8_to_bcd
   import clkdiv_bcd_pkg::*;
(
   input  logic [7:0] bin_i,
   output bcd_t       bcd_o
);

   // [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary being shifted in
   logic [19:0] sr;

   always_comb begin
      sr = {12'd0, bin_i};
      for (int i = 0; i < 8; i++) begin
         if (sr[11:8] >= 4'd5)  sr[11:8]  = sr[11:8]  + 4'd3;
         if (sr[15:12] >= 4'd5) sr[15:12] = sr[15:12] + 4'd3;
         sr = {sr[18:0], 1'b0};
      end
      bcd_o = sr[19:8];
   end

endmodule

// File: rtl/clkdiv_bcd_unit.sv
// Timebase-and-conversion unit: 1 Hz count strobe, ~1 kHz digit-scan strobe,
// and a registered BCD split of an 8-bit value for the display mux.
module clkdiv_bcd_unit
   import clkdiv_bcd_pkg::*;
#(
   parameter int SEC_HALF   = SEC_HALF_DEFAULT,
   parameter int DIGIT_HALF = DIGIT_HALF_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   clkdiv_bcd_unit_if.slave   bus
);

   logic [1:0] tgl;
   bcd_t       bcd_d;
   bcd_t       bcd_q;

   // Channel 0 is the seconds strobe, channel 1 the digit-scan strobe.
   for (genvar g = 0; g < 2; g++) begin : g_div
      localparam int HALF = (g == 0) ? SEC_HALF : DIGIT_HALF;
      localparam int CW   = cnt_width(HALF);
      localparam logic [CW-1:0] LAST = CW'(HALF - 1);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          tgl_q, tgl_d;

      always_comb begin
         cnt_d = cnt_q + 1'b1;
         tgl_d = tgl_q;
         if (cnt_q == LAST) begin
            cnt_d = '0;
            tgl_d = ~tgl_q;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q <= '0;
            tgl_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            tgl_q <= tgl_d;
         end
      end

      assign tgl[g] = tgl_q;
   end

   bin8_to_bcd u_bcd (
      .bin_i (bus.eight_bit_value),
      .bcd_o (bcd_d)
   );

   always_ff @(posedge clk) begin
      if (rst) bcd_q <= '0;
      else     bcd_q <= bcd_d;
   end

   assign bus.divided_clk = tgl[0];
   assign bus.digit_clk   = tgl[1];
   assign bus.hundreds    = bcd_q.hundreds;
   assign bus.tens        = bcd_q.tens;
   assign bus.ones        = bcd_q.ones;

endmodule

// File: tb/tb_clkdiv_bcd_unit.sv
// Bench for clkdiv_bcd_unit: a SEC_HALF=5/DIGIT_HALF=2 instance plus a HALF=1
// instance sharing clock and reset, BCD results tracked through a queue.
module tb_clkdiv_bcd_unit;
   import clkdiv_bcd_pkg::*;

   localparam int SH = 5;
   localparam int DH = 2;

   typedef struct {
      logic [7:0] val;
      int         h;
      int         t;
      int         o;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   clkdiv_bcd_unit_if bus ();
   clkdiv_bcd_unit_if bus1 ();

   clkdiv_bcd_unit #(.SEC_HALF(SH), .DIGIT_HALF(DH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   clkdiv_bcd_unit #(.SEC_HALF(1), .DIGIT_HALF(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   int   n     = 0;      // edges since reset release
   bit   win_on = 1'b0;
   int   win_div_hi = 0;
   int   win_dig_hi = 0;
   logic [11:0] exp_q [$];
   vec_t vecs [7];

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, n);
      end
   endtask

   function automatic logic [11:0] ref_bcd(input int v);
      ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // One clock: drive at the falling edge, check 1 time unit after the rising edge.
   task automatic cycle(input logic r, input logic [7:0] v, input logic [11:0] exp_bcd);
      logic [11:0] e;
      int          ah, at, ao;
      @(negedge clk);
      rst = r;
      bus.eight_bit_value  = v;
      bus1.eight_bit_value = v;
      exp_q.push_back(r ? 12'd0 : exp_bcd);
      @(posedge clk);
      #1;
      if (r) n = 0;
      else   n++;
      ah = int'(bus.hundreds);
      at = int'(bus.tens);
      ao = int'(bus.ones);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
      end else begin
         e = exp_q.pop_front();
         chk("hundreds", ah, int'(e[11:8]));
         chk("tens",     at, int'(e[7:4]));
         chk("ones",     ao, int'(e[3:0]));
      end
      if (!r) chk("identity", ah * 100 + at * 10 + ao, int'(v));
      chk("tens_le9", int'(at <= 9), 1);
      chk("ones_le9", int'(ao <= 9), 1);
      chk("divided_clk",      int'(bus.divided_clk),  (n / SH) % 2);
      chk("digit_clk",        int'(bus.digit_clk),    (n / DH) % 2);
      chk("half1_divided",    int'(bus1.divided_clk), n % 2);
      chk("half1_digit",      int'(bus1.digit_clk),   n % 2);
      if (win_on) begin
         win_div_hi += int'(bus.divided_clk);
         win_dig_hi += int'(bus.digit_clk);
      end
   endtask

   initial begin
      vecs[0] = '{8'd0,   0, 0, 0};
      vecs[1] = '{8'd9,   0, 0, 9};
      vecs[2] = '{8'd10,  0, 1, 0};
      vecs[3] = '{8'd59,  0, 5, 9};
      vecs[4] = '{8'd99,  0, 9, 9};
      vecs[5] = '{8'd100, 1, 0, 0};
      vecs[6] = '{8'd255, 2, 5, 5};

      bus.eight_bit_value  = 8'd0;
      bus1.eight_bit_value = 8'd0;

      // Reset held three cycles with a nonzero value on the input.
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'd200, 12'd0);

      // BCD corner table; edges 1..7 after release.
      for (int i = 0; i < 7; i++)
         cycle(1'b0, vecs[i].val, {4'(vecs[i].h), 4'(vecs[i].t), 4'(vecs[i].o)});

      // Edge 8: divided_clk high, seconds counter at 3.
      cycle(1'b0, 8'd42, ref_bcd(42));
      chk("pre_reset_div_high", int'(bus.divided_clk), 1);

      // Single-cycle reset mid-operation, then reload of the same input.
      cycle(1'b1, 8'd77, 12'd0);
      chk("midrst_div_low", int'(bus.divided_clk), 0);
      chk("midrst_ones_zero", int'(bus.ones), 0);
      cycle(1'b0, 8'd77, ref_bcd(77));
      chk("reload_tens", int'(bus.tens), 7);

      // Exhaustive sweep one value per cycle; first 100 edges give the duty window.
      for (int v = 0; v < 256; v++) begin
         win_on = (n < 100);
         cycle(1'b0, 8'(v), ref_bcd(v));
      end
      win_on = 1'b0;
      chk("duty_divided_100", win_div_hi, 50);
      chk("duty_digit_100",   win_dig_hi, 50);

      // Random tail with a late reset.
      for (int i = 0; i < 20; i++) begin
         logic [7:0] rv;
         rv = 8'($urandom_range(0, 255));
         cycle(i == 10, rv, ref_bcd(int'(rv)));
      end

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clkdiv_bcd_unit.md
Name: clkdiv_bcd_unit

Overview:
Timebase-and-conversion unit for the MM:SS seven-segment clock.
- Derives two square-wave strobes from the board clock: a 1 Hz count clock and a ~1 kHz digit-scan clock.
- Registers the BCD decomposition of an 8-bit binary value into hundreds/tens/ones digits for the display mux.
- Instanced once per displayed value pair by the display top level.

Parameters:
SEC_HALF, 50_000_000, clk cycles per half-period of divided_clk (1 Hz at 100 MHz); legal range >= 1
DIGIT_HALF, 50_000, clk cycles per half-period of digit_clk (1 kHz at 100 MHz); legal range >= 1

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  reset, synchronous, active-high
eight_bit_value  input  8  unsigned binary value to convert
divided_clk  output  1  square wave, period 2*SEC_HALF clk cycles, 50% duty
digit_clk  output  1  square wave, period 2*DIGIT_HALF clk cycles, 50% duty
ones  output  4  BCD ones digit of eight_bit_value, registered
tens  output  4  BCD tens digit, registered
hundreds  output  4  BCD hundreds digit (0..2), registered

Behaviour:
Reset (rst high at a clk edge):
- Both divider counters go to 0.
- divided_clk = 0, digit_clk = 0, ones = tens = hundreds = 0.
- Reset wins over every other update on that edge.

Divider (two independent channels, same rule):
- Counter width is ceil(log2(HALF)), minimum 1 bit.
- Each clk edge out of reset: if counter == HALF-1, clear the counter and toggle the output; else increment the counter.
- First rising edge of divided_clk occurs SEC_HALF edges after reset release. Then it toggles every SEC_HALF edges.
- digit_clk behaves identically with DIGIT_HALF.
- HALF = 1 makes the output toggle on every edge (period 2 clk).
- Counters never exceed HALF-1. Wrap is silent. The two channels never interact.
- Outputs come directly from flops (glitch-free), suitable for use as downstream clock/enables.

BCD converter:
- Combinational double-dabble (shift-add-3) over 8 bits, then one register stage.
- Outputs reflect eight_bit_value sampled at the previous clk edge: latency 1 cycle.
- Required identity: hundreds*100 + tens*10 + ones == eight_bit_value.
- ones and tens are always in 0..9; hundreds is in 0..2.
- All 256 inputs are legal; no saturation.
- Input changing every cycle gives output tracking it every cycle.
- Reset mid-operation forces the digits to 0 on that edge. The next non-reset edge loads the current input.

Decomposition:
Shared package clkdiv_bcd_pkg:
- Constants CLK_HZ = 100_000_000, SEC_HALF_DEFAULT, DIGIT_HALF_DEFAULT.
- Typedef bcd_digit_t (4-bit).
Sub-module:
- One natural sub-module, bin8_to_bcd: purely combinational double-dabble.
- The parent registers its result. The parent also holds both divider channels, generated from one counter template.

Test Plan:
- Reset: SEC_HALF=5, DIGIT_HALF=2; hold rst 3 cycles -> all outputs 0 and counters 0 throughout.
- Divider timing: release rst with SEC_HALF=5 -> divided_clk rises at edge 5 and falls at edge 10, period 10; digit_clk (DIGIT_HALF=2) toggles every 2 edges, period 4; duty exactly 50% over 100 cycles.
- BCD corners: input 0 -> 0/0/0; 9 -> 0/0/9; 10 -> 0/1/0; 59 -> 0/5/9; 99 -> 0/9/9; 100 -> 1/0/0; 255 -> 2/5/5; each appears exactly one cycle after the input is applied.
- Exhaustive BCD: sweep 0..255, one value per cycle -> identity holds for every value; no digit ever > 9.
- Reset mid-operation: assert rst for 1 cycle while divided_clk is high with its counter at 3 -> next edge divided_clk = 0 and counter = 0; the following rise is SEC_HALF edges later; BCD outputs are 0 for exactly that cycle, then reload.
- HALF=1 edge case: SEC_HALF=1 -> divided_clk toggles every clk edge after reset release.
